// File: rtl/led_phy_pkg.sv
// Shared LED receive definitions: frame geometry, fixed frame patterns and rx state encoding.
// No logic; imported by the receiver, its interface and its sub-modules.
package led_phy_pkg;

    localparam int          FRAME_BITS  = 32;
    localparam logic [31:0] START_FRAME = 32'h0000_0000;
    localparam logic [31:0] END_FRAME   = 32'hFFFF_FFFF;
    localparam logic [2:0]  LED_HDR     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_LED  = 2'd2,
        ST_END  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/led_frame_rx_if.sv
// Frame delivery channel: captured LED frame plus its index, valid/ready handshake.
// Master drives frame/valid, slave drives ready.
interface led_frame_rx_if;

    logic [led_phy_pkg::FRAME_BITS-1:0] frame_data;
    logic [4:0]                         frame_idx;
    logic                               frame_valid;
    logic                               frame_ready;

    modport master (output frame_data, frame_idx, frame_valid, input frame_ready);
    modport slave  (input frame_data, frame_idx, frame_valid, output frame_ready);

endinterface

// File: rtl/led_rx_sync_edge.sv
// Purpose: SYNC_STAGES-deep synchronizers for led_sclk/led_sdi plus led_sclk rising-edge detect.
// Latency: bit event SYNC_STAGES+1 clk after the led_sclk rise; no backpressure (free-running).
module led_rx_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_i,
    input  logic sdi_i,
    output logic bit_evt_o,
    output logic bit_dat_o
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] sdi_q;
    logic                   sclk_prev_q;
    logic                   bit_evt_q;
    logic                   bit_dat_q;

    // sdi travels through the same depth as sclk so the sampled bit stays aligned with its edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q      <= '0;
            sdi_q       <= '0;
            sclk_prev_q <= 1'b0;
            bit_evt_q   <= 1'b0;
            bit_dat_q   <= 1'b0;
        end else begin
            sclk_q[0] <= sclk_i;
            sdi_q[0]  <= sdi_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_q[i] <= sclk_q[i-1];
                sdi_q[i]  <= sdi_q[i-1];
            end
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
            bit_evt_q   <= sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
            bit_dat_q   <= sdi_q[SYNC_STAGES-1];
        end
    end

    assign bit_evt_o = bit_evt_q;
    assign bit_dat_o = bit_dat_q;

endmodule

// File: rtl/led_frame_rx.sv
// Purpose: LED serial stream receiver (start frame hunt, N LED frames, end frame); LED_FRAME_RX_CHECK_EN adds header/end checks.
// Latency: frame_valid 1 clk after the 32nd bit event of a frame; done 1 clk after the end frame's last bit.
// Backpressure: one-entry output; a frame completing while valid&&!ready is dropped and err_overflow set.
module led_frame_rx
    import led_phy_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4:0]            led_num,
    input  logic                  led_sclk,
    input  logic                  led_sdi,
    led_frame_rx_if.master        frm,
    output logic                  done,
    output logic                  err_overflow,
    output logic                  err_frame
);

    logic bit_evt;
    logic bit_dat;

    led_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk_i    (led_sclk),
        .sdi_i     (led_sdi),
        .bit_evt_o (bit_evt),
        .bit_dat_o (bit_dat)
    );

    rx_state_t             state_q,   state_d;
    logic [4:0]            bit_cnt_q, bit_cnt_d;
    logic [4:0]            frm_cnt_q, frm_cnt_d;
    logic [4:0]            num_q,     num_d;
    logic [FRAME_BITS-1:0] shift_q,   shift_d;
    logic [FRAME_BITS-1:0] data_q,    data_d;
    logic [4:0]            idx_q,     idx_d;
    logic                  vld_q,     vld_d;
    logic                  done_q,    done_d;
    logic                  ovf_q,     ovf_d;
    logic [FRAME_BITS-1:0] shift_nx;

    assign shift_nx = {shift_q[FRAME_BITS-2:0], bit_dat};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        frm_cnt_d = frm_cnt_q;
        num_d     = num_q;
        shift_d   = shift_q;
        data_d    = data_q;
        idx_d     = idx_q;
        vld_d     = vld_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;

        // the output handshake runs regardless of en so a pending frame can always drain
        if (vld_q && frm.frame_ready) vld_d = 1'b0;

        if (!en) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            frm_cnt_d = '0;
            shift_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_HUNT;
                    ovf_d   = 1'b0;
                end
                ST_HUNT: if (bit_evt) begin
                    if (bit_dat) begin
                        bit_cnt_d = '0;
                    end else if (bit_cnt_q == 5'd31) begin
                        bit_cnt_d = '0;
                        frm_cnt_d = '0;
                        num_d     = led_num;
                        state_d   = ST_LED;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
                ST_LED: if (bit_evt) begin
                    shift_d   = shift_nx;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) begin
                        if (!vld_q || frm.frame_ready) begin
                            data_d = shift_nx;
                            idx_d  = frm_cnt_q;
                            vld_d  = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                        if (frm_cnt_q == num_q) begin
                            frm_cnt_d = '0;
                            state_d   = ST_END;
                        end else begin
                            frm_cnt_d = frm_cnt_q + 5'd1;
                        end
                    end
                end
                ST_END: if (bit_evt) begin
                    shift_d   = shift_nx;
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd31) begin
                        done_d  = 1'b1;
                        state_d = ST_HUNT;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            frm_cnt_q <= '0;
            num_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            frm_cnt_q <= frm_cnt_d;
            num_q     <= num_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef LED_FRAME_RX_CHECK_EN
    logic ferr_q;
    logic last_bit;

    assign last_bit = en && bit_evt && (bit_cnt_q == 5'd31);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_q <= 1'b0;
        end else if (en && state_q == ST_IDLE) begin
            ferr_q <= 1'b0;
        end else if (last_bit && state_q == ST_LED && shift_nx[FRAME_BITS-1 -: 3] != LED_HDR) begin
            ferr_q <= 1'b1;
        end else if (last_bit && state_q == ST_END && shift_nx != END_FRAME) begin
            ferr_q <= 1'b1;
        end
    end

    assign err_frame = ferr_q;
`else
    assign err_frame = 1'b0;
`endif

    assign frm.frame_data  = data_q;
    assign frm.frame_idx   = idx_q;
    assign frm.frame_valid = vld_q;
    assign done            = done_q;
    assign err_overflow    = ovf_q;

endmodule

// File: tb/tb_led_frame_rx.sv
// Bench for led_frame_rx: table-driven streams, hand sequences for backpressure/reset/enable,
// and random streams checked against a bit-level stream parser.
module tb_led_frame_rx;

`ifdef LED_FRAME_RX_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, en, led_sclk, led_sdi;
    logic [4:0] led_num;
    logic       done, err_overflow, err_frame;

    led_frame_rx_if ifc ();

    led_frame_rx #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .led_num      (led_num),
        .led_sclk     (led_sclk),
        .led_sdi      (led_sdi),
        .frm          (ifc),
        .done         (done),
        .err_overflow (err_overflow),
        .err_frame    (err_frame)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] cap_d[$];
    logic [4:0]  cap_i[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (ifc.frame_valid && ifc.frame_ready) begin
            cap_d.push_back(ifc.frame_data);
            cap_i.push_back(ifc.frame_idx);
        end
        if (done) done_cnt++;
    end

    bit          bq[$];
    logic [31:0] ex_d[$];
    logic [4:0]  ex_i[$];
    int          ex_done;
    logic        ex_ferr;

    typedef struct packed {
        logic [4:0]        num;
        logic              glitch;
        logic [3:0][31:0]  w;
        logic [31:0]       endw;
        logic              ferr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 31; b >= 0; b--) bq.push_back(w[b]);
    endtask

    function automatic logic [31:0] word_at(input int p);
        logic [31:0] w;
        for (int b = 0; b < 32; b++) w[31-b] = bq[p+b];
        return w;
    endfunction

    task automatic send_bit(input logic b);
        led_sdi  = b;
        led_sclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        led_sclk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_range(input int from, input int to);
        for (int i = from; i < to; i++) send_bit(bq[i]);
    endtask

    task automatic restart();
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1 en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic build_vec(input vec_t v);
        bq.delete();
        if (v.glitch) begin
            for (int i = 0; i < 31; i++) bq.push_back(1'b0);
            bq.push_back(1'b1);
        end
        push_word(32'h0);
        for (int f = 0; f <= int'(v.num); f++) push_word(v.w[f]);
        push_word(v.endw);
    endtask

    // Reference: scan for 32 zeros, then num+1 LED frames, then one end frame, repeat.
    task automatic model(input int num);
        int z = 0;
        int i = 0;
        logic [31:0] w;
        ex_d.delete(); ex_i.delete(); ex_done = 0; ex_ferr = 1'b0;
        while (i < bq.size()) begin
            z = bq[i] ? 0 : z + 1;
            i++;
            if (z == 32) begin
                z = 0;
                for (int f = 0; f <= num && i + 32 <= bq.size(); f++) begin
                    w = word_at(i);
                    ex_d.push_back(w);
                    ex_i.push_back(5'(f));
                    if (w[31:29] != 3'b111) ex_ferr = 1'b1;
                    i += 32;
                end
                if (i + 32 <= bq.size()) begin
                    w = word_at(i);
                    ex_done++;
                    if (w != 32'hFFFF_FFFF) ex_ferr = 1'b1;
                    i += 32;
                end
            end
        end
    endtask

    task automatic compare_run(input string tag, input int cbase, input int dbase);
        check($sformatf("%s_nfr", tag), 32'(cap_d.size() - cbase), 32'(ex_d.size()));
        for (int i = 0; i < ex_d.size(); i++) begin
            if (cbase + i < cap_d.size()) begin
                check($sformatf("%s_d%0d", tag, i), cap_d[cbase+i], ex_d[i]);
                check($sformatf("%s_i%0d", tag, i), 32'(cap_i[cbase+i]), 32'(ex_i[i]));
            end
        end
        check($sformatf("%s_done", tag), 32'(done_cnt - dbase), 32'(ex_done));
        check($sformatf("%s_ovf", tag), 32'(err_overflow), 32'h0);
        check($sformatf("%s_ferr", tag), 32'(err_frame), 32'(CHK & ex_ferr));
    endtask

    task automatic run_full(input string tag, input int num);
        int cb, db;
        cb = cap_d.size();
        db = done_cnt;
        send_range(0, bq.size());
        repeat (8) @(posedge clk);
        #1;
        compare_run(tag, cb, db);
    endtask

    function automatic vec_t mk(input logic [4:0] num, input logic glitch, input logic [31:0] w0,
                                input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                                input logic [31:0] endw, input logic ferr);
        vec_t v;
        v.num = num; v.glitch = glitch; v.endw = endw; v.ferr = ferr;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        return v;
    endfunction

    vec_t vt[5];
    vec_t base;

    initial begin
        int cb, db, num, plen;
        logic [31:0] w;

        vt[0] = mk(5'd2, 1'b0, 32'hE011_2233, 32'hE144_5566, 32'hFF77_8899, 32'h0, 32'hFFFF_FFFF, 1'b0);
        vt[1] = mk(5'd2, 1'b1, 32'hE011_2233, 32'hE144_5566, 32'hFF77_8899, 32'h0, 32'hFFFF_FFFF, 1'b0);
        vt[2] = mk(5'd0, 1'b0, 32'hE0AB_CDEF, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        vt[3] = mk(5'd3, 1'b0, 32'h6011_2233, 32'hE000_0001, 32'hFFFF_FFFF, 32'hE800_0000, 32'hFFFF_FFFF, 1'b1);
        vt[4] = mk(5'd1, 1'b0, 32'hE123_4567, 32'hF89A_BCDE, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b1);
        base  = vt[0];

        rst_n = 1'b0; en = 1'b0; led_sclk = 1'b0; led_sdi = 1'b0; led_num = 5'd0;
        ifc.frame_ready = 1'b1;
        #12;
        check("rst_valid", 32'(ifc.frame_valid), 32'h0);
        check("rst_data", ifc.frame_data, 32'h0);
        check("rst_idx", 32'(ifc.frame_idx), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ovf", 32'(err_overflow), 32'h0);
        check("rst_ferr", 32'(err_frame), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // table-driven streams
        for (int t = 0; t < 5; t++) begin
            restart();
            led_num = vt[t].num;
            build_vec(vt[t]);
            ex_d.delete(); ex_i.delete();
            for (int f = 0; f <= int'(vt[t].num); f++) begin
                ex_d.push_back(vt[t].w[f]);
                ex_i.push_back(5'(f));
            end
            ex_done = 1;
            ex_ferr = vt[t].ferr;
            run_full($sformatf("vec%0d", t), int'(vt[t].num));
        end

        // backpressure: first frame held, later frames dropped
        restart();
        led_num = 5'd2;
        build_vec(base);
        ifc.frame_ready = 1'b0;
        cb = cap_d.size(); db = done_cnt;
        send_range(0, bq.size());
        repeat (8) @(posedge clk);
        #1;
        check("bp_valid", 32'(ifc.frame_valid), 32'h1);
        check("bp_data", ifc.frame_data, 32'hE011_2233);
        check("bp_idx", 32'(ifc.frame_idx), 32'h0);
        check("bp_ovf", 32'(err_overflow), 32'h1);
        check("bp_done", 32'(done_cnt - db), 32'h1);
        check("bp_ncap", 32'(cap_d.size() - cb), 32'h0);
        ifc.frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_drain", 32'(cap_d.size() - cb), 32'h1);
        check("bp_vld_off", 32'(ifc.frame_valid), 32'h0);

        // asynchronous reset at bit 17 of frame 1
        restart();
        led_num = 5'd2;
        build_vec(base);
        send_range(0, 32 + 32 + 17);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("ar_data", ifc.frame_data, 32'h0);
        check("ar_valid", 32'(ifc.frame_valid), 32'h0);
        check("ar_ovf", 32'(err_overflow), 32'h0);
        led_sclk = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model(2);
        run_full("ar_after", 2);

        // enable drop at bit 10 of frame 0
        restart();
        led_num = 5'd2;
        build_vec(base);
        cb = cap_d.size();
        send_range(0, 32 + 10);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("en_ncap", 32'(cap_d.size() - cb), 32'h0);
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model(2);
        run_full("en_after", 2);

        // random streams against the parser model; led_num is disturbed once LED frames are flowing
        for (int r = 0; r < 3; r++) begin
            restart();
            num = $urandom_range(0, 31);
            led_num = 5'(num);
            bq.delete();
            plen = $urandom_range(1, 12);
            for (int i = 0; i < plen - 1; i++) bq.push_back(1'($urandom));
            bq.push_back(1'b1);
            push_word(32'h0);
            for (int f = 0; f <= num; f++) begin
                w = $urandom;
                if ($urandom_range(0, 3) != 0) w[31:29] = 3'b111;
                push_word(w);
            end
            push_word(($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'hFFFF_FFFF);
            model(num);
            cb = cap_d.size(); db = done_cnt;
            send_range(0, plen + 64 + 8);
            led_num = ~5'(num);
            send_range(plen + 64 + 8, bq.size());
            repeat (8) @(posedge clk);
            #1;
            compare_run($sformatf("rnd%0d", r), cb, db);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_frame_rx.md
LED_FRAME_RX -- requirements
Module: led_frame_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on led_sclk/led_sdi.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port en  input  1  receiver enable; low forces IDLE.
REQ-005 SHALL have port led_num  input  5  LED frame count minus one (N = led_num+1, 1..32).
REQ-006 SHALL have port led_sclk  input  1  serial LED clock, asynchronous to clk.
REQ-007 SHALL have port led_sdi  input  1  serial LED data, MSB first, valid on led_sclk rising edge.
REQ-008 SHALL have port frame_data  output  32  captured LED frame.
REQ-009 SHALL have port frame_idx  output  5  index of frame_data within the stream, 0..N-1.
REQ-010 SHALL have port frame_valid  output  1  frame_data/frame_idx valid.
REQ-011 SHALL have port frame_ready  input  1  downstream accepts the frame when frame_valid is high.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the end frame completes.
REQ-013 SHALL have port err_overflow  output  1  sticky: a frame was dropped due to backpressure.
REQ-014 SHALL have port err_frame  output  1  sticky: bad LED header or bad end frame.

Function
REQ-015 SHALL sample led_sdi on each synchronized led_sclk rising edge ("bit event"), detected one clk after the last synchronizer stage.
REQ-016 SHALL implement states IDLE, HUNT, LED, END; en=1 moves IDLE->HUNT on the next clk.
REQ-017 In HUNT SHALL count consecutive zero bits; any one bit clears the count; on the 32nd consecutive zero SHALL latch led_num and enter LED.
REQ-018 In LED SHALL shift 32 bits per frame; on the 32nd bit SHALL load frame_data and frame_idx and assert frame_valid the next clk.
REQ-019 SHALL hold frame_valid, frame_data and frame_idx stable until the frame_valid&&frame_ready cycle, then deassert frame_valid.
REQ-020 If a new frame completes while frame_valid&&!frame_ready, SHALL drop the new frame, keep the old one and set err_overflow; a completion in the same cycle as a handshake SHALL load normally.
REQ-021 After frame N-1 SHALL enter END, shift 32 bits, pulse done on the clk after the 32nd bit, and return to HUNT.
REQ-022 Bit and frame counters SHALL be 5-bit, wrapping 31->0 only on frame completion; led_num changes outside HUNT SHALL be ignored.
REQ-023 en deasserted in any state SHALL return to IDLE next clk, clear counters and shift register, and leave a pending frame_valid and the sticky flags untouched.
REQ-024 err_overflow and err_frame SHALL clear only on reset or an IDLE->HUNT transition.

Reset
REQ-025 rst_n low SHALL asynchronously force state=IDLE, frame_data=0, frame_idx=0, frame_valid=0, done=0, err_overflow=0, err_frame=0, counters and synchronizers=0.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first bit event after release SHALL be processed only in HUNT.

Configuration
REQ-027 With LED_FRAME_RX_CHECK_EN defined, SHALL set err_frame when an LED frame's top 3 bits are not 3'b111 (frame still delivered) or the end frame is not 32'hFFFF_FFFF (done still pulsed).
REQ-028 Without LED_FRAME_RX_CHECK_EN, err_frame SHALL be tied 0 and no header/end content checks synthesized.

Structure
REQ-029 Package led_phy_pkg SHALL hold the rx state enum, FRAME_BITS=32, START_FRAME=32'h0, END_FRAME=32'hFFFF_FFFF, LED_HDR=3'b111.
REQ-030 Sub-module led_rx_sync_edge SHALL contain the SYNC_STAGES synchronizers and led_sclk rising-edge detector.

Verification
REQ-031 led_num=2, 32 zeros, frames E0112233/E1445566/FF778899, 32 ones, ready=1 -> three frame_valid with idx 0,1,2, one done pulse, no errors.
REQ-032 Same stream, frame_ready=0 until after END -> frame_data=E0112233 held, err_overflow=1, frames 1,2 lost, done pulses.
REQ-033 31 zeros, one 1, 32 zeros then valid frames -> HUNT restarts, stream decoded once correctly.
REQ-034 CHECK_EN, frame 0=60112233 -> frame delivered, err_frame=1; end frame FFFF_FFFE -> err_frame=1, done pulses; without macro err_frame stays 0.
REQ-035 rst_n low at bit 17 of frame 1 -> all outputs 0 asynchronously; after release a complete stream decodes normally.
REQ-036 en low at bit 10 of frame 0, then high -> IDLE, then HUNT; next full stream decodes with idx starting at 0.
